// File: rtl/llc_mesi_ctrl_if.sv
// Request, bus, snoop, L1-message and response signals of the LLC MESI controller.
// The controller takes the slave view; the requester/bus model takes the master view.
interface llc_mesi_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              bus_valid;
    logic [2:0]        bus_op;
    logic [1:0]        snoop_in;
    logic [1:0]        snoop_out;
    logic              msg_valid;
    logic [2:0]        msg;
    logic              resp_valid;
    logic              resp_hit;

    modport master (
        output req_valid, req_op, req_addr, snoop_in,
        input  req_ready, bus_valid, bus_op, snoop_out, msg_valid, msg, resp_valid, resp_hit
    );

    modport slave (
        input  req_valid, req_op, req_addr, snoop_in,
        output req_ready, bus_valid, bus_op, snoop_out, msg_valid, msg, resp_valid, resp_hit
    );
endinterface

// File: rtl/llc_mesi_ctrl.sv
// Set-associative LLC controller with MESI line states, tree-PLRU replacement and snoop handling.
// Optional statistics counters are built only when LLC_STATS_EN is defined.
module llc_mesi_ctrl #(
    parameter int NUM_SETS   = 16384,
    parameter int ASSOC      = 16,
    parameter int LINE_BYTES = 64,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    llc_mesi_ctrl_if.slave   cif
`ifdef LLC_STATS_EN
    ,
    output logic [CNT_W-1:0] cache_rds,
    output logic [CNT_W-1:0] cache_wrs,
    output logic [CNT_W-1:0] cache_hits,
    output logic [CNT_W-1:0] cache_misses
`endif
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int LA_W  = ADDR_W - OFF_W;
    localparam int TAG_W = LA_W - IDX_W;
    localparam int WAY_W = $clog2(ASSOC);
    localparam int PL_W  = ASSOC - 1;

    localparam logic [3:0] OP_RD = 4'd0, OP_WR = 4'd1, OP_IRD = 4'd2, OP_SRD = 4'd3;
    localparam logic [3:0] OP_SRWIM = 4'd5, OP_SINV = 4'd6, OP_CLR = 4'd8, OP_NOP = 4'd9;
    localparam logic [2:0] BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_WRITE = 3'd2, BUS_INV = 3'd3, BUS_RWIM = 3'd4;
    localparam logic [2:0] MSG_NONE = 3'd0, MSG_GET = 3'd1, MSG_SEND = 3'd2, MSG_INV = 3'd3, MSG_EVICT = 3'd4;
    localparam logic [1:0] SN_HIT = 2'd0, SN_HITM = 2'd1, SN_NOHIT = 2'd2, SN_NORES = 2'd3;
    localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_WB, S_EVICT, S_FILL, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q;
    logic [LA_W-1:0]    la_q;
    logic [WAY_W-1:0]   way_q;
    logic               hit_q;
    logic [IDX_W-1:0]   sweep_q;

    logic [TAG_W-1:0]   tags_q [NUM_SETS][ASSOC];
    logic [1:0]         mesi_q [NUM_SETS][ASSOC];
    logic [PL_W-1:0]    plru_q [NUM_SETS];

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] p, input logic [WAY_W-1:0] w);
        logic [WAY_W-1:0] n;
        n = '0;
        for (int l = 0; l < WAY_W; l++) begin
            p[n] = w[WAY_W-1-l];
            n    = WAY_W'(2 * int'(n) + 1 + int'(w[WAY_W-1-l]));
        end
        return p;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] p);
        logic [WAY_W-1:0] n, v;
        logic             d;
        n = '0;
        v = '0;
        for (int l = 0; l < WAY_W; l++) begin
            d            = ~p[n];
            v[WAY_W-1-l] = d;
            n            = WAY_W'(2 * int'(n) + 1 + int'(d));
        end
        return v;
    endfunction

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit, free, l1_op;
    logic [WAY_W-1:0] hit_way, free_way, vic_way, alloc_way;
    logic [1:0]       hit_st, vic_st;

    assign idx   = la_q[IDX_W-1:0];
    assign tag   = la_q[LA_W-1 -: TAG_W];
    assign l1_op = (op_q == OP_RD) || (op_q == OP_WR) || (op_q == OP_IRD);

    // Descending scan so the lowest matching/invalid way wins.
    always_comb begin
        hit      = 1'b0;
        free     = 1'b0;
        hit_way  = '0;
        free_way = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (mesi_q[idx][w] != ST_I && tags_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (mesi_q[idx][w] == ST_I) begin
                free     = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    assign vic_way   = plru_victim(plru_q[idx]);
    assign alloc_way = free ? free_way : vic_way;
    assign hit_st    = mesi_q[idx][hit_way];
    assign vic_st    = mesi_q[idx][vic_way];

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_CLEAR;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR:  if (sweep_q == IDX_W'(NUM_SETS - 1)) state_d = (op_q == OP_CLR) ? S_RESP : S_IDLE;
            S_IDLE:   if (cif.req_valid) state_d = (cif.req_op == OP_CLR) ? S_CLEAR : S_LOOKUP;
            S_LOOKUP: begin
                if (l1_op && !hit) state_d = free ? S_FILL : ((vic_st == ST_M) ? S_WB : S_EVICT);
                else               state_d = S_RESP;
            end
            S_WB:     state_d = S_EVICT;
            S_EVICT:  state_d = S_FILL;
            S_FILL:   state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_CLEAR;
        endcase
    end

    logic       rdy, rsp, rsp_hit;
    logic [2:0] bop, mop;
    logic [1:0] sno;

    always_comb begin
        rdy     = 1'b0;
        rsp     = 1'b0;
        rsp_hit = 1'b0;
        bop     = BUS_NONE;
        mop     = MSG_NONE;
        sno     = SN_NORES;
        if (reset_n) begin
            case (state_q)
                S_IDLE:   rdy = 1'b1;
                S_LOOKUP: begin
                    case (op_q)
                        OP_RD, OP_IRD: if (hit) mop = MSG_SEND;
                        OP_WR:         if (hit && hit_st == ST_S) bop = BUS_INV;
                        OP_SRD: begin
                            sno = !hit ? SN_NOHIT : ((hit_st == ST_M) ? SN_HITM : SN_HIT);
                            if (hit && hit_st == ST_M) begin
                                bop = BUS_WRITE;
                                mop = MSG_GET;
                            end
                        end
                        OP_SRWIM: begin
                            sno = !hit ? SN_NOHIT : ((hit_st == ST_M) ? SN_HITM : SN_HIT);
                            if (hit && hit_st == ST_M) begin
                                bop = BUS_WRITE;
                                mop = MSG_EVICT;
                            end else if (hit) begin
                                mop = MSG_INV;
                            end
                        end
                        OP_SINV: begin
                            sno = (hit && hit_st == ST_S) ? SN_HIT : SN_NOHIT;
                            if (hit && hit_st == ST_S) mop = MSG_INV;
                        end
                        default: ;
                    endcase
                end
                S_WB: begin
                    bop = BUS_WRITE;
                    mop = MSG_GET;
                end
                S_EVICT:  mop = MSG_EVICT;
                S_FILL: begin
                    bop = (op_q == OP_WR) ? BUS_RWIM : BUS_READ;
                    mop = MSG_SEND;
                end
                S_RESP: begin
                    rsp     = 1'b1;
                    rsp_hit = hit_q;
                end
                default: ;
            endcase
        end
    end

    assign cif.req_ready  = rdy;
    assign cif.bus_valid  = (bop != BUS_NONE);
    assign cif.bus_op     = bop;
    assign cif.msg_valid  = (mop != MSG_NONE);
    assign cif.msg        = mop;
    assign cif.snoop_out  = sno;
    assign cif.resp_valid = rsp;
    assign cif.resp_hit   = rsp_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q    <= OP_NOP;
            la_q    <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
            sweep_q <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    for (int w = 0; w < ASSOC; w++) mesi_q[sweep_q][w] <= ST_I;
                    plru_q[sweep_q] <= '0;
                    sweep_q         <= sweep_q + 1'b1;
                end
                S_IDLE: begin
                    if (cif.req_valid) begin
                        op_q    <= cif.req_op;
                        la_q    <= cif.req_addr[ADDR_W-1:OFF_W];
                        sweep_q <= '0;
                    end
                end
                S_LOOKUP: begin
                    hit_q <= hit && (op_q < 4'd7);
                    way_q <= hit ? hit_way : alloc_way;
                    if (hit) begin
                        case (op_q)
                            OP_RD, OP_IRD: plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                            OP_WR: begin
                                plru_q[idx]          <= plru_touch(plru_q[idx], hit_way);
                                mesi_q[idx][hit_way] <= ST_M;
                            end
                            OP_SRD:   mesi_q[idx][hit_way] <= ST_S;
                            OP_SRWIM: mesi_q[idx][hit_way] <= ST_I;
                            OP_SINV:  if (hit_st == ST_S) mesi_q[idx][hit_way] <= ST_I;
                            default: ;
                        endcase
                    end
                end
                S_EVICT: mesi_q[idx][way_q] <= ST_I;
                S_FILL: begin
                    tags_q[idx][way_q] <= tag;
                    mesi_q[idx][way_q] <= (op_q == OP_WR) ? ST_M :
                                          ((cif.snoop_in == SN_NOHIT) ? ST_E : ST_S);
                    plru_q[idx]        <= plru_touch(plru_q[idx], way_q);
                end
                default: ;
            endcase
        end
    end

`ifdef LLC_STATS_EN
    logic [CNT_W-1:0] rds_q, wrs_q, hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (!reset_n || state_q == S_CLEAR) begin
            rds_q    <= '0;
            wrs_q    <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == S_RESP && l1_op) begin
            if (op_q != OP_WR && rds_q != '1)    rds_q    <= rds_q + 1'b1;
            if (op_q == OP_WR && wrs_q != '1)    wrs_q    <= wrs_q + 1'b1;
            if (hit_q && hits_q != '1)           hits_q   <= hits_q + 1'b1;
            if (!hit_q && misses_q != '1)        misses_q <= misses_q + 1'b1;
        end
    end

    assign cache_rds    = reset_n ? rds_q    : '0;
    assign cache_wrs    = reset_n ? wrs_q    : '0;
    assign cache_hits   = reset_n ? hits_q   : '0;
    assign cache_misses = reset_n ? misses_q : '0;
`endif
endmodule

// File: tb/tb_llc_mesi_ctrl.sv
// Directed-vector bench for llc_mesi_ctrl at default geometry (16384 sets, 16 ways, 64-byte lines).
module tb_llc_mesi_ctrl;
    localparam logic [3:0] OP_RD = 0, OP_WR = 1, OP_IRD = 2, OP_SRD = 3, OP_SWR = 4, OP_SRWIM = 5, OP_SINV = 6;
    localparam logic [3:0] OP_UND = 7, OP_CLR = 8, OP_NOP = 9;
    localparam logic [2:0] B_NONE = 0, B_READ = 1, B_WRITE = 2, B_INV = 3, B_RWIM = 4;
    localparam logic [2:0] M_NONE = 0, M_GET = 1, M_SEND = 2, M_INV = 3, M_EVICT = 4;
    localparam logic [1:0] SN_HIT = 0, SN_HITM = 1, SN_NOHIT = 2, SN_NORES = 3;
    localparam int SETS = 16384;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    llc_mesi_ctrl_if #(.ADDR_W(32)) cif ();

`ifdef LLC_STATS_EN
    logic [31:0] c_rds, c_wrs, c_hits, c_misses;
`endif

    llc_mesi_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cif     (cif.slave)
`ifdef LLC_STATS_EN
        ,
        .cache_rds    (c_rds),
        .cache_wrs    (c_wrs),
        .cache_hits   (c_hits),
        .cache_misses (c_misses)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    logic [2:0] tr_bus [10];
    logic [2:0] tr_msg [10];
    logic [1:0] tr_snp [10];
    int         tr_cyc;
    logic       tr_hit;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cif.req_ready && n < 20000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    // Cycle k is the k-th cycle after the accepting edge; per-cycle bus/msg/snoop are recorded.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [1:0] snp, input int maxc);
        int n;
        for (int k = 0; k < 10; k++) begin
            tr_bus[k] = B_NONE;
            tr_msg[k] = M_NONE;
            tr_snp[k] = SN_NORES;
        end
        tr_cyc = 0;
        tr_hit = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cif.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cif.req_ready) begin
            chk("ready_timeout", 64'd0, 64'd1);
            return;
        end
        cif.req_valid = 1'b1;
        cif.req_op    = op;
        cif.req_addr  = addr;
        cif.snoop_in  = snp;
        @(posedge clk);
        #1 cif.req_valid = 1'b0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (k < 10) begin
                tr_bus[k] = cif.bus_valid ? cif.bus_op : B_NONE;
                tr_msg[k] = cif.msg_valid ? cif.msg : M_NONE;
                tr_snp[k] = cif.snoop_out;
            end
            if (cif.resp_valid) begin
                tr_cyc = k;
                tr_hit = cif.resp_hit;
                break;
            end
        end
        if (tr_cyc == 0) chk("resp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int   n;
        logic bad;
        cif.req_valid = 1'b0;
        cif.req_op    = OP_NOP;
        cif.req_addr  = '0;
        cif.snoop_in  = SN_NOHIT;
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {cif.req_ready, cif.bus_valid, cif.msg_valid, cif.resp_valid, cif.resp_hit,
                         cif.bus_op, cif.msg, cif.snoop_out}, {5'b0, B_NONE, M_NONE, SN_NORES});
`ifdef LLC_STATS_EN
        chk("rst_cnt", {c_rds, c_wrs, c_hits, c_misses}, 128'd0);
`endif
        reset_n = 1'b1;
        wait_ready(n);
        chk("sweep_len", n, SETS);

        // Read miss to a free way, then a read hit; line filled as E.
        issue(OP_RD, 32'h0000_1000, SN_NOHIT, 10);
        chk("rd_miss_c1", {tr_bus[1], tr_msg[1], tr_snp[1]}, {B_NONE, M_NONE, SN_NORES});
        chk("rd_miss_c2", {tr_bus[2], tr_msg[2]}, {B_READ, M_SEND});
        chk("rd_miss_rsp", {tr_cyc[7:0], 7'b0, tr_hit}, {8'd3, 8'd0});
        issue(OP_RD, 32'h0000_1000, SN_NOHIT, 10);
        chk("rd_hit_rsp", {tr_cyc[7:0], 7'b0, tr_hit}, {8'd2, 8'd1});
        chk("rd_hit_c1", {tr_bus[1], tr_msg[1]}, {B_NONE, M_SEND});

        // E -> M silently, snoop read of M, then write to S needs INVALIDATE.
        issue(OP_WR, 32'h0000_1000, SN_NOHIT, 10);
        chk("wr_e_hit", {tr_cyc[7:0], 7'b0, tr_hit, tr_bus[1], tr_msg[1]}, {8'd2, 8'd1, B_NONE, M_NONE});
        issue(OP_SRD, 32'h0000_1000, SN_NOHIT, 10);
        chk("srd_m", {tr_snp[1], tr_bus[1], tr_msg[1], tr_cyc[7:0]}, {SN_HITM, B_WRITE, M_GET, 8'd2});
        issue(OP_WR, 32'h0000_1000, SN_NOHIT, 10);
        chk("wr_s_inv", {tr_bus[1], tr_msg[1], tr_snp[1], tr_cyc[7:0]}, {B_INV, M_NONE, SN_NORES, 8'd2});
        issue(OP_SRD, 32'h0000_1000, SN_NOHIT, 10);
        chk("srd_m2", {tr_snp[1], tr_bus[1], tr_msg[1]}, {SN_HITM, B_WRITE, M_GET});
        issue(OP_SRD, 32'h0000_1000, SN_NOHIT, 10);
        chk("srd_s", {tr_snp[1], tr_bus[1], tr_msg[1]}, {SN_HIT, B_NONE, M_NONE});

        // Snoop RWIM / invalidate / write on another line.
        issue(OP_RD, 32'h0000_2040, SN_NOHIT, 10);
        issue(OP_SRWIM, 32'h0000_2040, SN_NOHIT, 10);
        chk("srwim_e", {tr_snp[1], tr_bus[1], tr_msg[1], tr_cyc[7:0]}, {SN_HIT, B_NONE, M_INV, 8'd2});
        issue(OP_RD, 32'h0000_2040, SN_HIT, 10);
        chk("rd_after_rwim", {tr_cyc[7:0], 7'b0, tr_hit}, {8'd3, 8'd0});
        issue(OP_SINV, 32'h0000_2040, SN_NOHIT, 10);
        chk("sinv_s", {tr_snp[1], tr_msg[1], tr_bus[1]}, {SN_HIT, M_INV, B_NONE});
        issue(OP_SINV, 32'h0000_2040, SN_NOHIT, 10);
        chk("sinv_i", {tr_snp[1], tr_msg[1]}, {SN_NOHIT, M_NONE});
        issue(OP_SRD, 32'h0000_2040, SN_NOHIT, 10);
        chk("srd_miss", {tr_snp[1], tr_bus[1], tr_cyc[7:0]}, {SN_NOHIT, B_NONE, 8'd2});
        issue(OP_WR, 32'h0000_2040, SN_NOHIT, 10);
        chk("wr_miss", {tr_bus[2], tr_msg[2], tr_cyc[7:0]}, {B_RWIM, M_SEND, 8'd3});
        issue(OP_SWR, 32'h0000_2040, SN_NOHIT, 10);
        chk("swr", {tr_snp[1], tr_bus[1], tr_msg[1], tr_cyc[7:0]}, {SN_NORES, B_NONE, M_NONE, 8'd2});
        issue(OP_SRWIM, 32'h0000_2040, SN_NOHIT, 10);
        chk("srwim_m", {tr_snp[1], tr_bus[1], tr_msg[1]}, {SN_HITM, B_WRITE, M_EVICT});

        // Set 2 filled with clean reads; 17th read evicts a clean victim.
        for (int t = 1; t <= 17; t++) begin
            issue(OP_RD, (32'(t) << 20) | 32'h80, SN_NOHIT, 10);
            if (t <= 16) chk("set2_fill", tr_cyc, 3);
        end
        chk("clean_vic", {tr_cyc[7:0], tr_bus[2], tr_msg[2], tr_bus[3], tr_msg[3]},
            {8'd4, B_NONE, M_EVICT, B_READ, M_SEND});

        // Set 0 filled with writes; 17th write evicts dirty way 0.
        for (int t = 1; t <= 17; t++) begin
            issue(OP_WR, 32'(t) << 20, SN_NOHIT, 10);
            if (t <= 16) chk("set0_fill", {tr_cyc[7:0], tr_bus[2]}, {8'd3, B_RWIM});
        end
        chk("dirty_vic_rsp", {tr_cyc[7:0], 7'b0, tr_hit}, {8'd5, 8'd0});
        chk("dirty_vic_seq", {tr_bus[1], tr_msg[1], tr_bus[2], tr_msg[2], tr_bus[3], tr_msg[3], tr_bus[4], tr_msg[4]},
            {B_NONE, M_NONE, B_WRITE, M_GET, B_NONE, M_EVICT, B_RWIM, M_SEND});
        issue(OP_RD, 32'(2) << 20, SN_NOHIT, 10);
        chk("set0_tag2_hit", {tr_cyc[7:0], 7'b0, tr_hit}, {8'd2, 8'd1});
        issue(OP_RD, 32'(1) << 20, SN_NOHIT, 10);
        chk("set0_tag1_gone", {tr_cyc[7:0], 7'b0, tr_hit, tr_bus[2]}, {8'd5, 8'd0, B_WRITE});
        issue(OP_RD, 32'(9) << 20, SN_NOHIT, 10);
        chk("set0_tag9_gone", tr_hit, 1'b0);

        // No-op and undefined op.
        issue(OP_NOP, 32'h0000_1000, SN_NOHIT, 10);
        chk("nop", {tr_cyc[7:0], 7'b0, tr_hit, tr_bus[1], tr_msg[1], tr_snp[1]}, {8'd2, 8'd0, B_NONE, M_NONE, SN_NORES});
        issue(OP_UND, 32'h0000_1000, SN_NOHIT, 10);
        chk("undef", {tr_cyc[7:0], 7'b0, tr_hit, tr_bus[1], tr_msg[1]}, {8'd2, 8'd0, B_NONE, M_NONE});

        // Reset during LOOKUP: no response, fresh sweep, cache empty afterwards.
        @(negedge clk);
        cif.req_valid = 1'b1;
        cif.req_op    = OP_RD;
        cif.req_addr  = 32'h0000_3000;
        @(posedge clk);
        #1 cif.req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        bad     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cif.resp_valid || cif.req_ready || cif.bus_valid || cif.msg_valid) bad = 1'b1;
        end
        chk("rst_mid_quiet", bad, 1'b0);
        reset_n = 1'b1;
        wait_ready(n);
        chk("rst_mid_sweep", n, SETS);
        issue(OP_RD, 32'h0000_1000, SN_NOHIT, 10);
        chk("post_rst_miss", {tr_cyc[7:0], 7'b0, tr_hit}, {8'd3, 8'd0});

        // Clear sweep, then statistics over 3 reads + 1 write, then clear again.
        issue(OP_CLR, 32'h0, SN_NOHIT, 20000);
        chk("clr_len", tr_cyc, SETS + 1);
        issue(OP_RD, 32'h0000_1000, SN_NOHIT, 10);
        chk("clr_miss", {tr_cyc[7:0], 7'b0, tr_hit}, {8'd3, 8'd0});
        issue(OP_IRD, 32'h0000_1000, SN_NOHIT, 10);
        chk("ird_hit", {tr_cyc[7:0], 7'b0, tr_hit, tr_msg[1]}, {8'd2, 8'd1, M_SEND});
        issue(OP_RD, 32'h0000_1000, SN_NOHIT, 10);
        issue(OP_WR, 32'h0000_1000, SN_NOHIT, 10);
        @(negedge clk);
`ifdef LLC_STATS_EN
        chk("stats", {c_rds, c_wrs, c_hits, c_misses}, {32'd3, 32'd1, 32'd3, 32'd1});
`endif
        issue(OP_CLR, 32'h0, SN_NOHIT, 20000);
        chk("clr2_len", tr_cyc, SETS + 1);
        @(negedge clk);
`ifdef LLC_STATS_EN
        chk("stats_clr", {c_rds, c_wrs, c_hits, c_misses}, 128'd0);
`endif
        issue(OP_RD, 32'h0000_1000, SN_NOHIT, 10);
        chk("clr2_miss", {tr_cyc[7:0], 7'b0, tr_hit}, {8'd3, 8'd0});

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/llc_mesi_ctrl.md
LLC_MESI_CTRL -- requirements
Module: llc_mesi_ctrl

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16384, number of sets (power of 2, >=2).
REQ-002 SHALL have parameter ASSOC, default 16, ways per set (power of 2, >=2).
REQ-003 SHALL have parameter LINE_BYTES, default 64, line size in bytes (power of 2, >=4).
REQ-004 SHALL have parameter ADDR_W, default 32, address width.
REQ-005 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-006 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-008 SHALL have port req_valid  in  1, and port req_ready  out  1; a request is accepted on the edge where both are high.
REQ-009 SHALL have port req_op  in  4  op code: 0 L1 data read, 1 L1 write, 2 L1 instr read, 3 snoop read, 4 snoop write, 5 snoop RWIM, 6 snoop invalidate, 8 clear, 9 no-op.
REQ-010 SHALL have port req_addr  in  ADDR_W  split as tag | index (log2 NUM_SETS) | offset (log2 LINE_BYTES).
REQ-011 SHALL have port bus_valid  out  1, and port bus_op  out  3  (0 NONE, 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM).
REQ-012 SHALL have port snoop_in  in  2  other-cache result for own READ (0 HIT, 1 HITM, 2 NOHIT), sampled in the cycle bus_valid=1 and bus_op=READ.
REQ-013 SHALL have port snoop_out  out  2  own result for snooped ops (0 HIT, 1 HITM, 2 NOHIT, 3 NORESULT).
REQ-014 SHALL have port msg_valid  out  1, and port msg  out  3  L1 message (0 NONE, 1 GETLINE, 2 SENDLINE, 3 INVALIDATELINE, 4 EVICTLINE).
REQ-015 SHALL have port resp_valid  out  1, and port resp_hit  out  1  single-cycle completion pulse and hit flag.
REQ-016 SHALL have ports cache_rds, cache_wrs, cache_hits, cache_misses  out  CNT_W  statistics (LLC_STATS_EN only).

Function
REQ-017 SHALL implement states CLEAR, IDLE, LOOKUP, WB, EVICT, FILL, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL, in every state, drive bus_valid, msg_valid and resp_valid as one-cycle pulses, with at most one bus op and one message per cycle.
REQ-019 SHALL capture op and address on acceptance and go to LOOKUP; tag match means equal tag and MESI state not I.
REQ-020 SHALL complete a hit or any snoop op with resp_valid exactly 2 cycles after acceptance (LOOKUP -> RESP).
REQ-021 SHALL handle read hits (0/2) with msg SENDLINE and a PLRU update; write hit in S: bus INVALIDATE, line -> M; in E: line -> M with no bus op; in M: no change.
REQ-022 SHALL allocate on L1 read/write miss: lowest-index invalid way, else the PLRU victim.
REQ-023 SHALL process a victim in state M in WB (bus WRITE, msg GETLINE) then EVICT (msg EVICTLINE); a clean victim goes directly to EVICT; the victim line becomes I.
REQ-024 SHALL in FILL issue bus READ for a read miss (line -> S on HIT/HITM, E on NOHIT) or bus RWIM for a write miss (line -> M), together with msg SENDLINE, then go to RESP.
REQ-025 SHALL give miss latency (acceptance to resp_valid) of 3 cycles with a free way, 4 with a clean victim, 5 with a dirty victim.
REQ-026 SHALL handle snoop read hit as: M -> S, snoop_out HITM, bus WRITE, msg GETLINE; E/S -> S, snoop_out HIT; on a miss, snoop_out NOHIT.
REQ-027 SHALL handle snoop RWIM hit as: M -> I, HITM, bus WRITE, msg EVICTLINE; E/S -> I, HIT, msg INVALIDATELINE; on a miss, NOHIT.
REQ-028 SHALL handle snoop invalidate on S as S -> I, snoop_out HIT, msg INVALIDATELINE; other states unchanged, NOHIT; snoop write leaves state unchanged with NORESULT.
REQ-029 SHALL never allocate or update PLRU on snoop ops; snoop_out SHALL be NORESULT for non-snoop ops.
REQ-030 SHALL keep ASSOC-1 tree-PLRU bits per set; on access each node on the path records the taken direction (0 left, 1 right), and victim search follows the complement.
REQ-031 SHALL make op 8 enter CLEAR, sweep one set per cycle for NUM_SETS cycles (all ways I, PLRU 0, counters 0), then RESP; op 9 and undefined codes complete in 2 cycles with no side effects.

Reset
REQ-032 SHALL, while reset_n=0, force all pulse outputs, resp_hit and counters to 0, bus_op NONE, msg NONE and snoop_out NORESULT.
REQ-033 SHALL, on reset release, run a CLEAR sweep of NUM_SETS cycles with req_ready=0; reset mid-operation SHALL abandon that op with no response pulse and restart the sweep.

Configuration
REQ-034 SHALL, with macro LLC_STATS_EN defined, count rds (ops 0/2), wrs (op 1), hits and misses (ops 0/1/2 only), each incremented at RESP and saturating at 2^CNT_W-1; without the macro, the counter ports and logic SHALL be absent.

Verification
REQ-035 SHALL cover: reset, then 16384 cycles -> req_ready=1, every lookup misses.
REQ-036 SHALL cover: op 0 addr 0x0000_1000 with snoop_in NOHIT -> bus READ and SENDLINE in cycle 2, resp_valid cycle 3 resp_hit=0, line E; repeating the op -> resp_valid cycle 2, resp_hit=1.
REQ-037 SHALL cover: op 1 to an S line -> bus INVALIDATE, line M; then op 3 same addr -> snoop_out HITM, bus WRITE, msg GETLINE, line S.
REQ-038 SHALL cover: 17 op-1 writes to distinct tags in set 0 (ASSOC=16) -> 17th write gets WB (WRITE+GETLINE), EVICT (EVICTLINE) on the way 0 PLRU victim, RWIM, resp_valid cycle 5.
REQ-039 SHALL cover: op 5 on an E line -> snoop_out HIT, msg INVALIDATELINE, line I; following op 0 misses.
REQ-040 SHALL cover: with LLC_STATS_EN, 3 reads + 1 write, then op 8 -> counters 3/1/x/y before op 8, all 0 after the sweep.
